// File: rtl/btn_event_arbiter.sv
// Push-button front end: two-flop synchroniser and stability-counter debounce per channel,
// with a round-robin arbiter that turns debounced presses into one valid/ready event stream.
module btn_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 100000,
  localparam int ID_W      = $clog2(N_BTN)
) (
  input  logic              clk100_i,
  input  logic              rst_i,
  input  logic [N_BTN-1:0]  btn_i,
  output logic [N_BTN-1:0]  btn_state_o,
  output logic              ev_valid_o,
  output logic [ID_W-1:0]   ev_id_o,
  output logic              ev_overrun_o,
  input  logic              ev_ready_i
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_BTN - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  logic [N_BTN-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [N_BTN-1:0] btn_state_q, btn_state_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] ovr_q, ovr_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  state_e           state_q, state_d;
  logic             ev_valid_q, ev_valid_d;
  logic [ID_W-1:0]  ev_id_q, ev_id_d;
  logic             ev_overrun_q, ev_overrun_d;

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] grant_oh;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;

  // Synchroniser and debounce: any sample equal to the current state restarts the window.
  always_comb begin
    s0_d        = btn_i;
    s1_d        = s0_q;
    btn_state_d = btn_state_q;
    press       = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s1_q[i] == btn_state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]       = '0;
        btn_state_d[i] = s1_q[i];
        press[i]       = s1_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int unsigned idx;
    logic        hit;
    idx       = 0;
    hit       = 1'b0;
    grant_any = 1'b0;
    grant_id  = last_grant_q;
    for (int k = 1; k <= N_BTN; k++) begin
      idx       = (int'(last_grant_q) + k) % N_BTN;
      hit       = !grant_any && pending_q[idx];
      grant_id  = hit ? ID_W'(idx) : grant_id;
      grant_any = grant_any | hit;
    end
  end

  // Arbiter FSM, output registers and pending/overrun bookkeeping (a new press beats a grant).
  always_comb begin
    state_d      = state_q;
    ev_valid_d   = ev_valid_q;
    ev_id_d      = ev_id_q;
    ev_overrun_d = ev_overrun_q;
    last_grant_d = last_grant_q;
    grant_oh     = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          ev_valid_d         = 1'b1;
          ev_id_d            = grant_id;
          ev_overrun_d       = ovr_q[grant_id];
          last_grant_d       = grant_id;
          grant_oh[grant_id] = 1'b1;
          state_d            = PRESENT;
        end else begin
          ev_valid_d = 1'b0;
        end
      end
      PRESENT: begin
        if (ev_ready_i) begin
          ev_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          ev_valid_d = 1'b1;
        end
      end
      default: begin
        ev_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
    pending_d = (pending_q & ~grant_oh) | press;
    ovr_d     = (ovr_q | (press & pending_q)) & ~grant_oh;
  end

  // All state, including the registered outputs.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      s0_q         <= '0;
      s1_q         <= '0;
      btn_state_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q    <= '0;
      ovr_q        <= '0;
      last_grant_q <= LAST_ID;
      state_q      <= IDLE;
      ev_valid_q   <= 1'b0;
      ev_id_q      <= '0;
      ev_overrun_q <= 1'b0;
    end else begin
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      btn_state_q  <= btn_state_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q    <= pending_d;
      ovr_q        <= ovr_d;
      last_grant_q <= last_grant_d;
      state_q      <= state_d;
      ev_valid_q   <= ev_valid_d;
      ev_id_q      <= ev_id_d;
      ev_overrun_q <= ev_overrun_d;
    end
  end

  assign btn_state_o  = btn_state_q;
  assign ev_valid_o   = ev_valid_q;
  assign ev_id_o      = ev_id_q;
  assign ev_overrun_o = ev_overrun_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: a DEB_CYCLES=4 instance for the timing scenarios
// and a DEB_CYCLES=100000 instance for the bounce smoke test.
module tb_btn_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready, ready_big;
  logic [3:0] btn, btn_big, state, state_big;
  logic       valid, ovr, valid_big, ovr_big;
  logic [1:0] id, id_big;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  btn_event_arbiter #(.N_BTN(4), .DEB_CYCLES(4)) dut (
    .clk100_i(clk), .rst_i(rst), .btn_i(btn), .btn_state_o(state),
    .ev_valid_o(valid), .ev_id_o(id), .ev_overrun_o(ovr), .ev_ready_i(ready)
  );

  btn_event_arbiter #(.N_BTN(4), .DEB_CYCLES(100000)) dut_big (
    .clk100_i(clk), .rst_i(rst), .btn_i(btn_big), .btn_state_o(state_big),
    .ev_valid_o(valid_big), .ev_id_o(id_big), .ev_overrun_o(ovr_big), .ev_ready_i(ready_big)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; btn = 4'b0000;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Waits for a presented event and, with ready high, lets it be consumed.
  task automatic wait_ev(output logic [1:0] got_id, output logic got_ovr, output bit ok);
    ok = 1'b0; got_id = 2'b00; got_ovr = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (valid) begin
        got_id = id; got_ovr = ovr; ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; btn = 4'b0000; btn_big = 4'b0000; ready_big = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({state, valid, id, ovr} !== 8'h00) begin
      n_bad++; $display("FAIL reset_small: got %b want 00000000", {state, valid, id, ovr});
    end
    n_cmp++;
    if ({state_big, valid_big, id_big, ovr_big} !== 8'h00) begin
      n_bad++; $display("FAIL reset_big: got %b want 00000000", {state_big, valid_big, id_big, ovr_big});
    end
  endtask

  task automatic test_single_press();
    int evs;
    do_reset(); ready = 1'b1;
    btn = 4'b0001;
    repeat (5) tick();
    n_cmp++;
    if (state !== 4'b0000) begin
      n_bad++; $display("FAIL single_state_k4: got %b want 0000", state);
    end
    tick();
    n_cmp++;
    if ({state, valid} !== 5'b00010) begin
      n_bad++; $display("FAIL single_state_k5: got %b want 00010", {state, valid});
    end
    tick();
    n_cmp++;
    if ({valid, id, ovr} !== 4'b1000) begin
      n_bad++; $display("FAIL single_event_k6: got %b want 1000", {valid, id, ovr});
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL single_one_cycle: got %b want 0", valid);
    end
    btn = 4'b0000; evs = 0;
    repeat (12) begin tick(); if (valid) evs++; end
    n_cmp++;
    if (state !== 4'b0000 || evs !== 0) begin
      n_bad++; $display("FAIL release_no_event: state %b events %0d want 0000 and 0", state, evs);
    end
  endtask

  task automatic test_bounce();
    int seen;
    do_reset(); ready = 1'b1;
    btn = 4'b0010;
    repeat (3) tick();
    btn = 4'b0000; seen = 0;
    repeat (12) begin tick(); if (valid || state != 4'b0000) seen++; end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL bounce_3_cycles: got %0d active cycles want 0", seen);
    end
    btn = 4'b0010;
    repeat (4) tick();
    btn = 4'b0000; seen = 0;
    repeat (14) begin tick(); if (valid) seen++; end
    n_cmp++;
    if (seen !== 1) begin
      n_bad++; $display("FAIL pulse_4_cycles: got %0d events want 1", seen);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] gid; logic gov; bit ok;
    logic [1:0] exp_a [3];
    logic [1:0] exp_b [2];
    exp_a[0] = 2'd0; exp_a[1] = 2'd2; exp_a[2] = 2'd3;
    exp_b[0] = 2'd0; exp_b[1] = 2'd3;
    do_reset(); ready = 1'b1;
    btn = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      wait_ev(gid, gov, ok);
      n_cmp++;
      if ({ok, gid, gov} !== {1'b1, exp_a[i], 1'b0}) begin
        n_bad++; $display("FAIL rr_first_%0d: ok %0d id %0d ovr %0d want id %0d ovr 0", i, ok, gid, gov, exp_a[i]);
      end
    end
    btn = 4'b0000;
    repeat (10) tick();
    btn = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      wait_ev(gid, gov, ok);
      n_cmp++;
      if ({ok, gid, gov} !== {1'b1, exp_b[i], 1'b0}) begin
        n_bad++; $display("FAIL rr_second_%0d: ok %0d id %0d ovr %0d want id %0d ovr 0", i, ok, gid, gov, exp_b[i]);
      end
    end
    btn = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_stall_overrun();
    logic [1:0] gid; logic gov; bit ok; int bad;
    do_reset(); ready = 1'b0;
    btn = 4'b0010;
    wait_valid(ok);
    n_cmp++;
    if ({ok, id} !== 3'b101) begin
      n_bad++; $display("FAIL stall_first: ok %0d id %0d want ok 1 id 1", ok, id);
    end
    bad = 0;
    btn = 4'b0110; repeat (8) begin tick(); if (valid !== 1'b1 || id !== 2'd1 || ovr !== 1'b0) bad++; end
    btn = 4'b0010; repeat (8) begin tick(); if (valid !== 1'b1 || id !== 2'd1 || ovr !== 1'b0) bad++; end
    btn = 4'b0110; repeat (8) begin tick(); if (valid !== 1'b1 || id !== 2'd1 || ovr !== 1'b0) bad++; end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad);
    end
    ready = 1'b1;
    wait_ev(gid, gov, ok);
    wait_ev(gid, gov, ok);
    n_cmp++;
    if ({ok, gid, gov} !== 4'b1101) begin
      n_bad++; $display("FAIL overrun_event: ok %0d id %0d ovr %0d want id 2 ovr 1", ok, gid, gov);
    end
    btn = 4'b0010;
    repeat (8) tick();
    btn = 4'b0110;
    wait_ev(gid, gov, ok);
    n_cmp++;
    if ({ok, gid, gov} !== 4'b1100) begin
      n_bad++; $display("FAIL overrun_cleared: ok %0d id %0d ovr %0d want id 2 ovr 0", ok, gid, gov);
    end
    btn = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_present();
    bit ok; int first; logic [1:0] fid;
    do_reset(); ready = 1'b0;
    btn = 4'b1000;
    wait_valid(ok);
    n_cmp++;
    if ({ok, id} !== 3'b111) begin
      n_bad++; $display("FAIL mid_present_setup: ok %0d id %0d want ok 1 id 3", ok, id);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({state, valid, id, ovr} !== 8'h00) begin
      n_bad++; $display("FAIL mid_reset_clear: got %b want 00000000", {state, valid, id, ovr});
    end
    first = 0; fid = 2'b00;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (valid && first == 0) begin first = j; fid = id; end
    end
    n_cmp++;
    if (first !== 7 || fid !== 2'd3) begin
      n_bad++; $display("FAIL mid_represent: edge %0d id %0d want edge 7 id 3", first, fid);
    end
    btn = 4'b0000; ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_long_window_smoke();
    int seen; int len;
    btn_big = 4'b0000; seen = 0;
    for (int b = 0; b < 12; b++) begin
      len = $urandom_range(20, 400);
      for (int c = 0; c < len; c++) begin
        btn_big = 4'($urandom);
        tick();
        if (valid_big || state_big != 4'b0000) seen++;
      end
      btn_big = 4'b0000;
      repeat (20) begin tick(); if (valid_big || state_big != 4'b0000) seen++; end
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL long_window_bounce: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; btn = 4'b0000; btn_big = 4'b0000; ready_big = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_stall_overrun();
    test_reset_mid_present();
    test_long_window_smoke();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
